// File: rtl/mem_stage.sv
// Data-memory stage: 2**ADDR_W x DATA_W word-addressed synchronous RAM, one shared read/write address.
// Latency: 1 cycle, address before edge N -> dout after edge N; no combinational input-to-dout path.
// Backpressure: none, always ready; no handshake or stall.
//
// Ports:
//   clk   core clock, all state updates on the rising edge
//   rst   synchronous active-high reset: clears dout, blocks the write, keeps memory contents
//   we    write enable, full-word store of din into mem[addr]
//   addr  word address shared by the read and write ports
//   din   store data
//   dout  registered load data
//
// Build option: define MEMSTAGE_WRITE_FIRST_EN to forward store data onto dout in the
// store cycle (write-first). Without it, a same-address read returns the old word (read-first).
module mem_stage #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] din,
   output logic [DATA_W-1:0] dout
);

   localparam int DEPTH = 2 ** ADDR_W;

   // Zero at time 0 so loads of never-written words return 0 instead of X.
   logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};
   logic [DATA_W-1:0] rd_data;

   always_ff @(posedge clk) begin
      if (!rst && we) begin
         mem[addr] <= din;
      end
   end

`ifdef MEMSTAGE_WRITE_FIRST_EN
   // Forwarding mux: the word being stored wins over the stale array contents.
   assign rd_data = we ? din : mem[addr];
`else
   // The array is sampled before this edge's write lands, giving read-first.
   assign rd_data = mem[addr];
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         dout <= '0;
      end else begin
         dout <= rd_data;
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

   localparam int ADDR_W = 10;
   localparam int DATA_W = 32;
   localparam int DEPTH  = 2 ** ADDR_W;
`ifdef MEMSTAGE_WRITE_FIRST_EN
   localparam bit WF = 1'b1;
`else
   localparam bit WF = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst;
   logic              we;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] din;
   logic [DATA_W-1:0] dout;

   int checks = 0;
   int errors = 0;

   mem_stage #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk  (clk),
      .rst  (rst),
      .we   (we),
      .addr (addr),
      .din  (din),
      .dout (dout)
   );

   always #5 clk = ~clk;

   // Reference model: a plain array plus the value dout must carry after each edge.
   logic [DATA_W-1:0] model_mem [DEPTH];
   logic [DATA_W-1:0] exp_dout;
   bit                started = 1'b0;

   initial begin
      for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
      exp_dout = '0;
   end

   always @(posedge clk) begin
      if (rst) begin
         exp_dout = '0;
      end else begin
         if (we && WF) exp_dout = din;
         else          exp_dout = model_mem[addr];
         if (we) model_mem[addr] = din;
      end
      started = 1'b1;
   end

   // Cycle-by-cycle comparison against the model, sampled on the falling edge.
   always @(negedge clk) begin
      if (started) begin
         checks++;
         if (dout !== exp_dout) begin
            errors++;
            $display("FAIL model_cmp t=%0t addr=%0d: dout=%h expected=%h", $time, addr, dout, exp_dout);
         end
      end
   end

   task automatic drive(input logic r, input logic w, input int a, input logic [DATA_W-1:0] d);
      rst  = r;
      we   = w;
      addr = ADDR_W'(a);
      din  = d;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [DATA_W-1:0] expv);
      checks++;
      if (dout !== expv) begin
         errors++;
         $display("FAIL %s: dout=%h expected=%h", name, dout, expv);
      end
   endtask

   initial begin
      rst = 1'b1; we = 1'b0; addr = '0; din = '0;

      // Reset state
      drive(1, 0, 0, 0);
      chk("reset", 32'h0);

      // Power-up read of never-written word
      for (int i = 0; i < 10; i++) begin
         drive(0, 0, 12, 12);
         chk("powerup_read", 32'h0);
      end

      // Store then load
      drive(0, 1, 12, 12);
      chk("store_first_edge", WF ? 32'd12 : 32'd0);
      for (int i = 0; i < 9; i++) begin
         drive(0, 1, 12, 12);
         chk("store_repeat", 32'd12);
      end
      drive(0, 0, 12, 0);
      chk("load_held", 32'd12);

      // Reset gating: write blocked, contents retained
      drive(1, 1, 5, 32'hDEADBEEF);
      chk("reset_gate_dout", 32'h0);
      drive(0, 0, 5, 0);
      chk("reset_gate_nowrite", 32'h0);
      drive(0, 0, 12, 0);
      chk("reset_retains", 32'd12);

      // Boundary addresses and aliasing
      drive(0, 1, 0, 32'hA5A5A5A5);
      drive(0, 1, 1023, 32'h5A5A5A5A);
      drive(0, 0, 0, 0);
      chk("addr0", 32'hA5A5A5A5);
      drive(0, 0, 1023, 0);
      chk("addr1023", 32'h5A5A5A5A);
      drive(0, 0, 1, 0);
      chk("addr1_no_alias", 32'h0);
      drive(0, 0, 1022, 0);
      chk("addr1022_no_alias", 32'h0);

      // Back-to-back accesses
      drive(0, 1, 3, 32'h11);
      drive(0, 1, 4, 32'h22);
      drive(0, 0, 3, 0);
      chk("b2b_rd3", 32'h11);
      drive(0, 0, 4, 0);
      chk("b2b_rd4", 32'h22);

      // Overwrite
      drive(0, 1, 12, 32'hFFFFFFFF);
      chk("overwrite_edge", WF ? 32'hFFFFFFFF : 32'd12);
      drive(0, 0, 12, 0);
      chk("overwrite_read", 32'hFFFFFFFF);

      // Mixed traffic over a small address window, checked by the model only
      for (int i = 0; i < 300; i++) begin
         drive(($urandom_range(0, 19) == 0), ($urandom_range(0, 1) == 1),
               ($urandom_range(0, 3) == 0) ? int'($urandom_range(1020, 1023)) : int'($urandom_range(0, 7)),
               $urandom);
      end
      drive(0, 0, 0, 0);
      @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
